// File: rtl/zigzag_scan_reader_pkg.sv
// rtl/zigzag_scan_reader_pkg.sv - zigzag address table, FSM state encoding and block depth
package zigzag_scan_reader_pkg;

  localparam int ZZ_DEPTH = 16;

  // Entry i lives at bits [4*i +: 4]; written MSB-first, so it reads as the reverse scan.
  localparam logic [63:0] ZZ_TABLE = {
    4'd15, 4'd14, 4'd11, 4'd7, 4'd10, 4'd13, 4'd12, 4'd9,
    4'd6,  4'd3,  4'd2,  4'd5, 4'd8,  4'd4,  4'd1,  4'd0
  };

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  function automatic logic [3:0] zz_addr(input logic [3:0] pos);
    return ZZ_TABLE[{pos, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/zigzag_out_fifo.sv
// rtl/zigzag_out_fifo.sv - 2-entry coefficient FIFO; head is presented combinationally
module zigzag_out_fifo #(
  parameter int WIDTH = 9,
  parameter int IW    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic [IW-1:0]    push_idx,
  input  logic             push_last,
  input  logic             pop,
  output logic [1:0]       count,
  output logic             head_valid,
  output logic [WIDTH-1:0] head_data,
  output logic [IW-1:0]    head_idx,
  output logic             head_last
);

  logic [WIDTH-1:0] data_q [2];
  logic [IW-1:0]    idx_q  [2];
  logic [1:0]       last_q;
  logic             wr_ptr;
  logic             rd_ptr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        data_q[i] <= '0;
        idx_q[i]  <= '0;
      end
      last_q <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (push) begin
        data_q[wr_ptr] <= push_data;
        idx_q[wr_ptr]  <= push_idx;
        last_q[wr_ptr] <= push_last;
        wr_ptr         <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign head_valid = (count != 2'd0);
  // Outputs read as zero when empty so stale entries never leak out.
  assign head_data  = head_valid ? data_q[rd_ptr] : '0;
  assign head_idx   = head_valid ? idx_q[rd_ptr]  : '0;
  assign head_last  = head_valid & last_q[rd_ptr];

endmodule

// File: rtl/zigzag_scan_reader.sv
// rtl/zigzag_scan_reader.sv - reads a 4x4 block from BRAM in zigzag order into a ready/valid stream
// ZIGZAG_REVERSE_SCAN_EN: when defined the table is walked from index 15 down to 0.
module zigzag_scan_reader
  import zigzag_scan_reader_pkg::*;
#(
  parameter int addrWIDTH = 4,
  parameter int WIDTH     = 9,
  parameter int DEPTH     = ZZ_DEPTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 busy,
  output logic                 enb,
  output logic [addrWIDTH-1:0] addrb,
  input  logic [WIDTH-1:0]     dob,
  output logic [WIDTH-1:0]     coef_data,
  output logic [addrWIDTH-1:0] coef_idx,
  output logic                 coef_valid,
  input  logic                 coef_ready,
  output logic                 coef_last,
  output logic                 done
);

  state_t               state;
  logic [4:0]           k;
  logic [3:0]           pos;
  logic                 rd_valid;
  logic [addrWIDTH-1:0] rd_idx;
  logic                 rd_last;
  logic [1:0]           fifo_count;
  logic [1:0]           credit_used;
  logic                 pop;
  logic                 accept;
  logic                 issue;
  logic                 last_issue;

  assign pop = coef_valid & coef_ready;

  // Counting this cycle's pop lets a read be issued into the slot being freed,
  // which is what sustains one coefficient per cycle with only two entries.
  assign credit_used = fifo_count + {1'b0, rd_valid} - {1'b0, pop};

  assign accept     = (state == ST_IDLE) && start;
  assign issue      = (accept || ((state == ST_READ) && (k < 5'(DEPTH)))) && (credit_used < 2'd2);
  assign last_issue = (k == 5'(DEPTH - 1));

`ifdef ZIGZAG_REVERSE_SCAN_EN
  assign pos = 4'(DEPTH - 1) - k[3:0];
`else
  assign pos = k[3:0];
`endif

  assign enb   = issue;
  assign addrb = issue ? addrWIDTH'(zz_addr(pos)) : '0;
  assign busy  = (state != ST_IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      k        <= '0;
      rd_valid <= 1'b0;
      rd_idx   <= '0;
      rd_last  <= 1'b0;
      done     <= 1'b0;
    end else begin
      done     <= 1'b0;
      rd_valid <= issue;
      if (issue) begin
        k       <= k + 5'd1;
        rd_idx  <= addrWIDTH'(pos);
        rd_last <= last_issue;
      end
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state <= (issue && last_issue) ? ST_DRAIN : ST_READ;
          end
        end
        ST_READ: begin
          if (issue && last_issue) begin
            state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (pop && coef_last) begin
            state <= ST_IDLE;
            k     <= '0;
            done  <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  zigzag_out_fifo #(
    .WIDTH (WIDTH),
    .IW    (addrWIDTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (rd_valid),
    .push_data  (dob),
    .push_idx   (rd_idx),
    .push_last  (rd_last),
    .pop        (pop),
    .count      (fifo_count),
    .head_valid (coef_valid),
    .head_data  (coef_data),
    .head_idx   (coef_idx),
    .head_last  (coef_last)
  );

endmodule

// File: tb/tb_zigzag_scan_reader.sv
// tb/tb_zigzag_scan_reader.sv - scoreboard bench for zigzag_scan_reader with a synchronous BRAM model
module tb_zigzag_scan_reader;

  localparam int AW = 4;
  localparam int W  = 9;
  localparam int D  = 16;
`ifdef ZIGZAG_REVERSE_SCAN_EN
  localparam int FIRST_IDX = 15;
`else
  localparam int FIRST_IDX = 0;
`endif

  typedef struct packed {
    logic [W-1:0]  data;
    logic [AW-1:0] idx;
    logic          last;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          busy;
  logic          enb;
  logic [AW-1:0] addrb;
  logic [W-1:0]  dob;
  logic [W-1:0]  coef_data;
  logic [AW-1:0] coef_idx;
  logic          coef_valid;
  logic          coef_ready;
  logic          coef_last;
  logic          done;

  int   tests = 0;
  int   fails = 0;
  exp_t exp_q[$];
  logic [W-1:0] ram [D];
  int   fwd_tab [16] = '{0, 1, 4, 8, 5, 2, 3, 6, 9, 12, 13, 10, 7, 11, 14, 15};

  always #5 clk = ~clk;

  zigzag_scan_reader #(.addrWIDTH(AW), .WIDTH(W), .DEPTH(D)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .busy       (busy),
    .enb        (enb),
    .addrb      (addrb),
    .dob        (dob),
    .coef_data  (coef_data),
    .coef_idx   (coef_idx),
    .coef_valid (coef_valid),
    .coef_ready (coef_ready),
    .coef_last  (coef_last),
    .done       (done)
  );

  always @(posedge clk) if (enb) dob <= ram[addrb];

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_block();
    for (int j = 0; j < 16; j++) begin
      exp_t e;
`ifdef ZIGZAG_REVERSE_SCAN_EN
      e.idx = AW'(15 - j);
`else
      e.idx = AW'(j);
`endif
      e.data = ram[fwd_tab[int'(e.idx)]];
      e.last = (j == 15);
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_done(input string name);
    bit seen = 1'b0;
    for (int c = 0; c < 200 && !seen; c++) begin
      step();
      if (done) seen = 1'b1;
    end
    check(name, int'(seen), 1);
    check({name, "_drained"}, exp_q.size(), 0);
  endtask

  exp_t held;
  bit   stall_hold = 1'b0;
  bit   pend_done  = 1'b0;

  always @(negedge clk) begin : monitor
    exp_t act;
    exp_t e;
    if (!rst) begin
      stall_hold = 1'b0;
      pend_done  = 1'b0;
    end else begin
      act = {coef_data, coef_idx, coef_last};
      if (done || pend_done) check("done_pulse", int'(done), int'(pend_done));
      pend_done = 1'b0;
      if (stall_hold) check("stall_stable", int'({coef_valid, act}), int'({1'b1, held}));
      stall_hold = 1'b0;
      if (coef_valid && coef_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_coef: got %0h with empty scoreboard", act);
        end else begin
          e = exp_q.pop_front();
          check("coef", int'(act), int'(e));
        end
        if (coef_last) pend_done = 1'b1;
      end else if (coef_valid) begin
        stall_hold = 1'b1;
        held       = act;
      end
    end
  end

  initial begin
    int first, nvalid, nenb, dn;
    bit seen;
    rst = 1'b0; start = 1'b0; coef_ready = 1'b1;
    for (int p = 0; p < D; p++) ram[p] = W'(p);
    repeat (3) step();
    check("rst_busy", int'(busy), 0);
    check("rst_enb", int'(enb), 0);
    check("rst_addrb", int'(addrb), 0);
    check("rst_valid", int'(coef_valid), 0);
    check("rst_data", int'(coef_data), 0);
    check("rst_idx", int'(coef_idx), 0);
    check("rst_last", int'(coef_last), 0);
    check("rst_done", int'(done), 0);
    rst = 1'b1;
    step();

    // Full-rate block
    push_block();
    start = 1'b1; first = -1; nvalid = 0; nenb = 0; dn = -1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (coef_valid) begin if (first < 0) first = c; nvalid++; end
      if (enb) nenb++;
      if (done && dn < 0) dn = c;
      if (c == 1) check("busy_c1", int'(busy), 1);
      step();
      start = 1'b0;
    end
    check("full_first_valid", first, 2);
    check("full_valid_cycles", nvalid, 16);
    check("full_reads", nenb, 16);
    check("full_done_cycle", dn, 18);
    check("full_drained", exp_q.size(), 0);

    // Alternating ready
    push_block();
    start = 1'b1; first = -1; nvalid = 0; dn = -1;
    for (int c = 0; c < 45; c++) begin
      coef_ready = c[0];
      @(negedge clk);
      if (coef_valid) begin if (first < 0) first = c; nvalid++; end
      if (done && dn < 0) dn = c;
      step();
      start = 1'b0;
    end
    coef_ready = 1'b1;
    check("toggle_first_valid", first, 2);
    check("toggle_valid_cycles", nvalid, 32);
    check("toggle_done_cycle", dn, 34);
    check("toggle_drained", exp_q.size(), 0);

    // Backpressure from the start
    push_block();
    start = 1'b1; coef_ready = 1'b0; nenb = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (enb) nenb++;
      if (c == 9) check("bp_enb_idle", int'(enb), 0);
      step();
      start = 1'b0;
    end
    check("bp_reads", nenb, 2);
    coef_ready = 1'b1;
    wait_done("bp_done");

    // Reset at coefficient 7, then a clean block
    for (int p = 0; p < D; p++) ram[p] = W'(p * 37 - 200);
    push_block();
    start = 1'b1; seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      step();
      start = 1'b0;
      if (coef_valid && coef_idx == AW'(7)) seen = 1'b1;
    end
    check("reached_idx7", int'(seen), 1);
    rst = 1'b0;
    #1;
    exp_q.delete();
    check("abort_busy", int'(busy), 0);
    check("abort_enb", int'(enb), 0);
    check("abort_addrb", int'(addrb), 0);
    check("abort_valid", int'(coef_valid), 0);
    check("abort_data", int'(coef_data), 0);
    check("abort_idx", int'(coef_idx), 0);
    check("abort_last", int'(coef_last), 0);
    check("abort_done", int'(done), 0);
    step(); step();
    rst = 1'b1;
    nvalid = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (coef_valid || enb) nvalid++;
    end
    check("no_residual", nvalid, 0);
    push_block();
    start = 1'b1;
    step();
    start = 1'b0;
    wait_done("restart_done");

    // Start while busy is ignored; start with done chains the next block
    push_block();
    start = 1'b1; step(); start = 1'b0;
    repeat (4) step();
    start = 1'b1; step(); start = 1'b0;
    wait_done("mid_start_done");
    push_block();
    start = 1'b1;
    @(negedge clk); check("chain_c0_valid", int'(coef_valid), 0);
    step(); start = 1'b0;
    @(negedge clk); check("chain_c1_valid", int'(coef_valid), 0);
    step();
    @(negedge clk);
    check("chain_c2_valid", int'(coef_valid), 1);
    check("chain_c2_idx", int'(coef_idx), FIRST_IDX);
    wait_done("chain_done");
    nvalid = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (coef_valid || busy) nvalid++;
    end
    check("final_idle", nvalid, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/zigzag_scan_reader.md
ZIGZAG_SCAN_READER -- requirements
Module: zigzag_scan_reader

Interface
REQ-001 The block SHALL have parameter addrWIDTH, default 4, meaning the BRAM address width.
REQ-002 The block SHALL have parameter WIDTH, default 9, meaning the coefficient width in bits (signed two's complement).
REQ-003 The block SHALL have parameter DEPTH, default 16, meaning coefficients per 4x4 block.
REQ-004 Port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 Port rst, input, 1 bit: asynchronous, active-low reset.
REQ-006 Port start, input, 1: one-cycle pulse meaning the block is fully written to BRAM.
REQ-007 Port busy, output, 1: high from accepted start until done.
REQ-008 Port enb, output, 1: BRAM read enable.
REQ-009 Port addrb, output, addrWIDTH: BRAM read address.
REQ-010 Port dob, input, WIDTH: BRAM read data, valid the cycle after enb.
REQ-011 Port coef_data, output, WIDTH: scanned coefficient.
REQ-012 Port coef_idx, output, addrWIDTH: scan index 0..15 of coef_data.
REQ-013 Port coef_valid, output, 1: coef_data/coef_idx/coef_last are valid.
REQ-014 Port coef_ready, input, 1: consumer accepts when coef_valid and coef_ready are both high.
REQ-015 Port coef_last, output, 1: high with the 16th coefficient of the block.
REQ-016 Port done, output, 1: one-cycle pulse the cycle after the last coefficient handshake.

Function
REQ-017 Raster position p (row*4+col) SHALL reside at BRAM address p.
REQ-018 Scan order SHALL be addresses 0,1,4,8,5,2,3,6,9,12,13,10,7,11,14,15 for coef_idx 0..15.
REQ-019 FSM states SHALL be IDLE, READ, DRAIN.
REQ-020 IDLE->READ on start; start while busy SHALL be ignored.
REQ-021 READ SHALL issue one read (enb=1, addrb=table[k], k++) per cycle when (buffered + in-flight) < 2.
REQ-022 READ->DRAIN after the 16th read is issued; DRAIN->IDLE with done pulse after the coef_last handshake.
REQ-023 Read data SHALL land in a 2-entry output FIFO; coef_* SHALL present the FIFO head.
REQ-024 With coef_ready held high, throughput SHALL be one coefficient per cycle; first coef_valid SHALL be 2 cycles after start.
REQ-025 Under backpressure (coef_ready low), no FIFO entry SHALL be lost or duplicated and coef_* SHALL stay stable while coef_valid is high.
REQ-026 enb SHALL be low whenever no read is issued; addrb is don't-care then.
REQ-027 Scan counter k SHALL be 5 bits internally so 16 is representable; no wrap into a second block.
REQ-028 Simultaneous FIFO push and pop SHALL keep occupancy unchanged.
REQ-029 start in the same cycle as done SHALL be accepted, starting the next block.

Reset
REQ-030 On rst low: state IDLE, k=0, FIFO empty, busy=0, enb=0, addrb=0, coef_valid=0, coef_data=0, coef_idx=0, coef_last=0, done=0.
REQ-031 Reset mid-block SHALL abort the block; no residual coefficient SHALL appear after release.

Configuration
REQ-032 Macro ZIGZAG_REVERSE_SCAN_EN defined: table SHALL be traversed from index 15 to 0 (address 15 first, coef_idx counts 15..0, coef_last with idx 0), for CAVLC reverse-order encoding.
REQ-033 Macro undefined: forward order per REQ-018.

Structure
REQ-034 Shared package SHALL hold the 16-entry zigzag address table, FSM state encoding, and DEPTH constant.
REQ-035 The 2-entry FIFO SHALL be sub-module zigzag_out_fifo; remaining logic inline.

Verification
REQ-036 BRAM preloaded with ram[p]=p, start, coef_ready=1 -> coef_data 0,1,4,8,5,2,3,6,9,12,13,10,7,11,14,15 on 16 consecutive cycles, coef_last on 15, done next cycle.
REQ-037 Same preload, coef_ready toggling 1010... -> identical sequence, each value held stable while stalled, total 32 cycles of valid activity.
REQ-038 coef_ready low for 10 cycles after start -> exactly 2 reads issued, then enb=0 until ready rises.
REQ-039 rst asserted at coefficient 7 -> all outputs zero; new start yields full sequence from idx 0.
REQ-040 start pulsed again mid-block -> ignored, exactly 16 coefficients emitted; start with done -> second block follows without gap.
REQ-041 ZIGZAG_REVERSE_SCAN_EN defined -> coef_data 15,14,11,7,10,13,12,9,6,3,2,5,8,4,1,0, coef_last with 0.
